// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the dm arbiter: DM_* access codes (same encodings as the
// ctrl_encode_def defines), arbiter FSM state encodings and the misalignment rule.
package dm_arbiter_pkg;

    localparam logic [2:0] DM_LB  = 3'b000;
    localparam logic [2:0] DM_LH  = 3'b001;
    localparam logic [2:0] DM_LW  = 3'b010;
    localparam logic [2:0] DM_LBU = 3'b100;
    localparam logic [2:0] DM_LHU = 3'b101;
    localparam logic [2:0] DM_SB  = 3'b000;
    localparam logic [2:0] DM_SH  = 3'b001;
    localparam logic [2:0] DM_SW  = 3'b010;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Byte ops never misalign, halfwords need addr[0]=0, words and undefined codes addr[1:0]=0.
    function automatic logic dm_misaligned(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            DM_LB, DM_LBU: dm_misaligned = 1'b0;
            DM_LH, DM_LHU: dm_misaligned = lo[0];
            default:       dm_misaligned = (lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-requester round-robin picker; the last-grant pointer favours port 0 after reset.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_reg;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11)
                gnt = last_reg ? 2'b01 : 2'b10;
            else
                gnt = req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_reg <= 1'b1;
        else if (gnt[0])
            last_reg <= 1'b0;
        else if (gnt[1])
            last_reg <= 1'b1;
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between two requesters: one registered access
// per transaction, misaligned accesses answered with rerr and never written.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [2:0]    op0,
    input  logic [2:0]    op1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          rerr,
    output logic          mem_wr,
    output logic [2:0]    mem_op,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    arb_state_t state_reg, state_next;

    logic [1:0]    req_vec, gnt_vec, rvalid_vec;
    logic          sel;
    logic          sel_we;
    logic [2:0]    sel_op;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          owner_reg, we_reg, mis_reg;
    logic [2:0]    op_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg, rdata_reg;

    assign req_vec = {req1, req0};

    rr_arb2 u_rr (
        .clk (clk),
        .rst (rst),
        .en  (state_reg == ARB_IDLE),
        .req (req_vec),
        .gnt (gnt_vec)
    );

    assign gnt0      = gnt_vec[0];
    assign gnt1      = gnt_vec[1];
    assign sel       = gnt_vec[1];
    assign sel_we    = sel ? we1    : we0;
    assign sel_op    = sel ? op1    : op0;
    assign sel_addr  = sel ? addr1  : addr0;
    assign sel_wdata = sel ? wdata1 : wdata0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE:   if (|req_vec) state_next = ARB_ACCESS;
            ARB_ACCESS: state_next = ARB_RESP;
            ARB_RESP:   state_next = ARB_IDLE;
            default:    state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= ARB_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_reg <= 1'b0;
            we_reg    <= 1'b0;
            mis_reg   <= 1'b0;
            op_reg    <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            if (|gnt_vec) begin
                owner_reg <= sel;
                we_reg    <= sel_we;
                mis_reg   <= dm_misaligned(sel_op, sel_addr[1:0]);
                op_reg    <= sel_op;
                addr_reg  <= sel_addr;
                wdata_reg <= sel_wdata;
            end
            // Stores and rejected accesses report zero data.
            if (state_reg == ARB_ACCESS)
                rdata_reg <= (!we_reg && !mis_reg) ? mem_dout : '0;
        end
    end

    // mem_wr is combinational on state so an asynchronous reset kills it at once.
    assign mem_wr   = (state_reg == ARB_ACCESS) && we_reg && !mis_reg;
    assign mem_op   = op_reg;
    assign mem_addr = addr_reg;
    assign mem_din  = wdata_reg;
    assign rdata    = rdata_reg;
    assign rerr     = (state_reg == ARB_RESP) && mis_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
        assign rvalid_vec[gi] = (state_reg == ARB_RESP) && (owner_reg == 1'(gi));
    end

    assign rvalid0 = rvalid_vec[0];
    assign rvalid1 = rvalid_vec[1];

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and access sequencer in front of the single-port data memory `dm`. It shares `dm` between the CPU load/store path (port 0) and the debug/program-loader path (port 1). It uses round-robin grant, registers each accepted request, and drives one memory access per transaction. Misaligned halfword/word accesses are rejected with an error response, and `dm` is never written for them. The block sits between the datapath's memory stage, the loader, and `dm`.

## Interface
- `AW`, default 9: byte-address width, matching `dm` `addr`.
- `DW`, default 32: data width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`/`req1`  in  1  access request from port 0 / port 1.
- `we0`/`we1`  in  1  1 = store, 0 = load.
- `op0`/`op1`  in  3  `DM_*` access code (LB/LBU/LH/LHU/LW/SB/SH/SW).
- `addr0`/`addr1`  in  AW  byte address.
- `wdata0`/`wdata1`  in  DW  store data, low-aligned as `dm` expects.
- `gnt0`/`gnt1`  out  1  request accepted this cycle (combinational).
- `rvalid0`/`rvalid1`  out  1  one-cycle response strobe, also issued for stores.
- `rdata`  out  DW  load result, shared by both ports and qualified by `rvalidN`.
- `rerr`  out  1  misaligned access, qualified by `rvalidN`.
- `mem_wr`, `mem_op[2:0]`, `mem_addr[AW-1:0]`, `mem_din[DW-1:0]`  out  drive `dm` `DMWr`/`DMOp`/`addr`/`din`.
- `mem_dout`  in  DW  `dm` `dout` (combinational read).

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS when any `reqN` is high.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Grants:
  - Grants are issued only in IDLE, and at most one `gntN` is high.
  - If a single port requests, it wins.
  - If both request, the port not granted last wins.
  - The last-granted pointer resets to 1, so port 0 wins the first tie.
- On the grant edge the block latches the owner, `we`, `op`, `addr`, `wdata`, and a misalign flag.
- Misalign rule:
  - LH/LHU/SH are misaligned when `addr[0]`=1.
  - LW/SW and undefined codes are misaligned when `addr[1:0]`≠0.
  - LB/LBU/SB are never misaligned.
- In ACCESS:
  - `mem_op`/`mem_addr`/`mem_din` come from the latched request.
  - `mem_wr` = latched `we` && !misalign.
  - `rdata` captures `mem_dout` at the end of ACCESS for loads.
  - `rdata` is 0 for stores and for misaligned accesses.
- In RESP, `rvalid` of the latched owner is high, and `rerr` = latched misalign flag.
- Outside ACCESS, `mem_wr`=0; `mem_op`/`mem_addr`/`mem_din` hold their last latched values.
- Requester rules:
  - A requester holds `req` and its fields stable until `gnt`.
  - It may drop or change them the cycle after `gnt`.
  - It must not re-request before its `rvalid`; if it does, the request simply waits in IDLE.

## Timing
- Cycle 0 (IDLE, `reqN`=1): `gntN`=1; the request is latched at the rising edge ending cycle 0.
- Cycle 1 (ACCESS): a store commits in `dm` at the edge ending cycle 1; a load's `mem_dout` is sampled at that same edge.
- Cycle 2 (RESP): `rvalidN`=1, with `rdata`/`rerr` valid; the next grant is possible in cycle 3.
- Performance: latency is 2 cycles from grant to `rvalid`, and throughput is one access per 3 cycles.
- Reset values: state=IDLE, pointer=1, `gnt0`/`gnt1`=0, `rvalid0`/`rvalid1`=0, `rerr`=0, `rdata`=0, `mem_wr`=0, `mem_op`/`mem_addr`/`mem_din`=0.
- Reset in ACCESS: `mem_wr` drops immediately, so no store commits. The pending transaction is dropped and gets no `rvalid`.
- A requester arriving during ACCESS or RESP waits for IDLE; no request is lost if it is held.

## Structure
- The `DM_*` op codes come from the shared `ctrl_encode_def` defines.
- Add to those shared defines: FSM state encodings `ARB_IDLE`, `ARB_ACCESS`, `ARB_RESP`, and a `dm_misaligned` rule description.
- One sub-module, `rr_arb2`: a 2-requester round-robin picker with a last-grant pointer, enabled only in IDLE.
- The misalign check and the request/response registers live in `dm_arbiter`.

## Test plan
- Port 0 stores SW 0xDEADBEEF to addr 0x010, then LW 0x010:
  - `gnt0` is high in IDLE.
  - `mem_wr` is high for exactly one cycle.
  - `rvalid0` arrives 2 cycles after the load's `gnt0`, with `rdata`=0xDEADBEEF and `rerr`=0.
- Both ports request on the same cycle after reset:
  - Port 0 is granted first, then port 1 when the FSM next returns to IDLE (cycle 3).
  - Held continuous requests alternate 0,1,0,1.
- Port 1 does SB 0xAA to 0x013 over word 0x11223344, then LB 0x013 and LBU 0x013:
  - LB returns 0xFFFFFFAA and LBU returns 0x000000AA.
  - LW 0x010 returns 0xAA223344.
- SH to 0x021 and LW from 0x022:
  - `mem_wr` stays 0 and memory is unchanged.
  - `rvalid` with `rerr`=1 and `rdata`=0.
- `rst` pulsed during the ACCESS cycle of an SW to 0x030:
  - `mem_wr` is 0 at the edge and word 0x030 keeps its old value.
  - No `rvalid` is issued; the next request is granted after reset release.
